// File: rtl/sample_history_buffer_if.sv
// Bus bundle for the sample history buffer: write strobes/samples, offset
// reads, clear control and per-channel fill counts.
//
// Handshake: there is no ready signal. A request (wr_en bit, rd_req, clear)
// is accepted on every rising edge where it is high and busy is low; rd_valid
// is high exactly one cycle after an accepted rd_req and qualifies rd_data for
// that cycle only. While busy is high, writes and reads are dropped, so the
// requester gates its strobes on busy.
interface sample_history_buffer_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         clear;
    logic                         busy;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH*DATA_W-1:0]     wr_data;
    logic                         rd_req;
    logic [CH_W-1:0]              rd_ch;
    logic [ADDR_W-1:0]            rd_offset;
    logic                         rd_valid;
    logic [DATA_W-1:0]            rd_data;
    logic [NUM_CH*(ADDR_W+1)-1:0] fill_cnt;
    logic                         dbg_state;  // 1 while the clear sweep runs

    modport master (
        output clear, wr_en, wr_data, rd_req, rd_ch, rd_offset,
        input  busy, rd_valid, rd_data, fill_cnt, dbg_state
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_req, rd_ch, rd_offset,
        output busy, rd_valid, rd_data, fill_cnt, dbg_state
    );
endinterface

// File: rtl/sample_history_buffer.sv
// Multi-channel circular history buffer. Each channel keeps its own write
// pointer and fill count; reads address x[n-k] relative to the newest sample
// and return zero for samples older than the history held. A clear sweep
// zeroes the storage one address per cycle across all channels.
module sample_history_buffer #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sample_history_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic                busy_q;
    logic [ADDR_W-1:0]   sweep_addr;
    logic [ADDR_W-1:0]   wr_ptr [NUM_CH];
    logic [ADDR_W:0]     fill   [NUM_CH];
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Sample storage; never reset, stale contents are hidden by fill gating.
    logic [DATA_W-1:0]   mem [NUM_CH][DEPTH];

    logic                rd_hit;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     rd_fill;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_result;

    // Resolve the read against pre-write pointer/count state of the selected channel.
    always_comb begin
        rd_hit  = 1'b0;
        rd_ptr  = '0;
        rd_fill = '0;
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == bus.rd_ch) begin
                rd_hit  = 1'b1;
                rd_ptr  = wr_ptr[c];
                rd_fill = fill[c];
            end
        end
        rd_addr = rd_ptr - ADDR_W'(1) - bus.rd_offset;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == bus.rd_ch) begin
                rd_word = mem[c][rd_addr];
            end
        end
        // Out-of-range channel or offset beyond the held history reads as zero.
        rd_result = (rd_hit && ({1'b0, bus.rd_offset} < rd_fill)) ? rd_word : '0;
    end

    // Control FSM: pointers, fill counts, clear sweep and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            sweep_addr <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_valid_q <= bus.rd_req;
                    if (bus.rd_req) begin
                        rd_data_q <= rd_result;
                    end
                    if (bus.clear) begin
                        // Clear wins over any same-cycle write.
                        state      <= ST_CLEAR;
                        busy_q     <= 1'b1;
                        sweep_addr <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            wr_ptr[c] <= '0;
                            fill[c]   <= '0;
                        end
                    end else begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (bus.wr_en[c]) begin
                                wr_ptr[c] <= wr_ptr[c] + ADDR_W'(1);
                                if (fill[c] != FULL_CNT) begin
                                    fill[c] <= fill[c] + (ADDR_W + 1)'(1);
                                end
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    rd_valid_q <= 1'b0;
                    sweep_addr <= sweep_addr + ADDR_W'(1);
                    if (sweep_addr == LAST_ADDR) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage writes: the sweep zeroes one address in every channel per cycle.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (state == ST_CLEAR) begin
                mem[c][sweep_addr] <= '0;
            end else if (!bus.clear && bus.wr_en[c]) begin
                mem[c][wr_ptr[c]] <= bus.wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.dbg_state = (state == ST_CLEAR);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fill
        assign bus.fill_cnt[g*(ADDR_W+1) +: (ADDR_W+1)] = fill[g];
    end
endmodule

// File: tb/tb_sample_history_buffer.sv
// Bench for sample_history_buffer: three builds (2ch/256, 4ch/16, 3ch/4)
// against a history model that keeps every sample written since the last
// clear and answers x[n-k] directly from that list.
module tb_sample_history_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sample_history_buffer_if #(.NUM_CH(2), .DATA_W(16), .DEPTH(256)) bus_a ();
    sample_history_buffer_if #(.NUM_CH(4), .DATA_W(16), .DEPTH(16))  bus_b ();
    sample_history_buffer_if #(.NUM_CH(3), .DATA_W(16), .DEPTH(4))   bus_c ();

    sample_history_buffer #(.NUM_CH(2), .DATA_W(16), .DEPTH(256)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    sample_history_buffer #(.NUM_CH(4), .DATA_W(16), .DEPTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    sample_history_buffer #(.NUM_CH(3), .DATA_W(16), .DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [15:0] m_smp [3][8][1024];
    int          m_wcnt [3][8];
    int          m_clr_left [3];
    logic        m_valid [3];
    logic [15:0] m_data [3];
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];

    function automatic int m_depth(input int d);
        return (d == 0) ? 256 : ((d == 1) ? 16 : 4);
    endfunction

    function automatic int m_nch(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 3);
    endfunction

    function automatic int m_fill(input int d, input int c);
        return (m_wcnt[d][c] < m_depth(d)) ? m_wcnt[d][c] : m_depth(d);
    endfunction

    function automatic logic [15:0] m_read(input int d, input int ch, input int off);
        if (ch >= m_nch(d)) return 16'h0;
        if (off >= m_fill(d, ch)) return 16'h0;
        return m_smp[d][ch][(m_wcnt[d][ch] - 1 - off) % 1024];
    endfunction

    task automatic q_push(input int d, input logic [15:0] e);
        case (d)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic q_pop(input int d, output bit ok, output logic [15:0] e);
        ok = 1'b0;
        e  = 16'h0;
        case (d)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 8; c++) m_wcnt[d][c] = 0;
            m_clr_left[d] = 0;
            m_valid[d]    = 1'b0;
            m_data[d]     = 16'h0;
        end
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endtask

    task automatic model_edge(input int d, input logic clr, input logic [7:0] wen,
                              input logic [127:0] wd, input logic req,
                              input int ch, input int off);
        logic [15:0] e;
        if (m_clr_left[d] > 0) begin
            m_valid[d] = 1'b0;
            m_clr_left[d]--;
        end else begin
            m_valid[d] = req;
            if (req) begin
                e = m_read(d, ch, off);
                m_data[d] = e;
                q_push(d, e);
            end
            if (clr) begin
                for (int c = 0; c < 8; c++) m_wcnt[d][c] = 0;
                m_clr_left[d] = m_depth(d);
            end else begin
                for (int c = 0; c < m_nch(d); c++) begin
                    if (wen[c]) begin
                        m_smp[d][c][m_wcnt[d][c] % 1024] = wd[c*16 +: 16];
                        m_wcnt[d][c]++;
                    end
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input logic v, input logic [15:0] data,
                       input logic b, input logic st, input logic [71:0] fills,
                       input int fw);
        bit          ok;
        logic [15:0] e;
        logic [71:0] mask;
        chk($sformatf("d%0d_valid", d), 32'(v), 32'(m_valid[d]));
        chk($sformatf("d%0d_busy", d), 32'(b), 32'(m_clr_left[d] > 0));
        chk($sformatf("d%0d_state", d), 32'(st), 32'(m_clr_left[d] > 0));
        if (m_valid[d]) begin
            q_pop(d, ok, e);
            if (!ok) chk($sformatf("d%0d_queue", d), 32'(0), 32'(1));
            else     chk($sformatf("d%0d_data", d), 32'(data), 32'(e));
        end else begin
            chk($sformatf("d%0d_hold", d), 32'(data), 32'(m_data[d]));
        end
        mask = (72'(1) << fw) - 72'(1);
        for (int c = 0; c < m_nch(d); c++) begin
            chk($sformatf("d%0d_fill%0d", d, c), 32'((fills >> (c * fw)) & mask),
                32'(m_fill(d, c)));
        end
    endtask

    // Compare process: every cycle out of reset, all three builds vs the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp(0, bus_a.rd_valid, bus_a.rd_data, bus_a.busy, bus_a.dbg_state, 72'(bus_a.fill_cnt), 9);
                cmp(1, bus_b.rd_valid, bus_b.rd_data, bus_b.busy, bus_b.dbg_state, 72'(bus_b.fill_cnt), 5);
                cmp(2, bus_c.rd_valid, bus_c.rd_data, bus_c.busy, bus_c.dbg_state, 72'(bus_c.fill_cnt), 3);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, bus_a.clear, 8'(bus_a.wr_en), 128'(bus_a.wr_data), bus_a.rd_req,
                       int'(bus_a.rd_ch), int'(bus_a.rd_offset));
            model_edge(1, bus_b.clear, 8'(bus_b.wr_en), 128'(bus_b.wr_data), bus_b.rd_req,
                       int'(bus_b.rd_ch), int'(bus_b.rd_offset));
            model_edge(2, bus_c.clear, 8'(bus_c.wr_en), 128'(bus_c.wr_data), bus_c.rd_req,
                       int'(bus_c.rd_ch), int'(bus_c.rd_offset));
        end
        @(negedge clk);
    endtask

    task automatic rd_a(input int ch, input int off, input logic [15:0] exp);
        bus_a.rd_req    = 1'b1;
        bus_a.rd_ch     = 1'(ch);
        bus_a.rd_offset = 8'(off);
        tick();
        chk($sformatf("a_lit_valid_ch%0d_k%0d", ch, off), 32'(bus_a.rd_valid), 32'(1));
        chk($sformatf("a_lit_data_ch%0d_k%0d", ch, off), 32'(bus_a.rd_data), 32'(exp));
    endtask

    task automatic rd_b(input int ch, input int off, input logic [15:0] exp);
        bus_b.rd_req    = 1'b1;
        bus_b.rd_ch     = 2'(ch);
        bus_b.rd_offset = 4'(off);
        tick();
        chk($sformatf("b_lit_valid_ch%0d_k%0d", ch, off), 32'(bus_b.rd_valid), 32'(1));
        chk($sformatf("b_lit_data_ch%0d_k%0d", ch, off), 32'(bus_b.rd_data), 32'(exp));
    endtask

    task automatic rd_c(input int ch, input int off, input logic [15:0] exp);
        bus_c.rd_req    = 1'b1;
        bus_c.rd_ch     = 2'(ch);
        bus_c.rd_offset = 2'(off);
        tick();
        chk($sformatf("c_lit_valid_ch%0d_k%0d", ch, off), 32'(bus_c.rd_valid), 32'(1));
        chk($sformatf("c_lit_data_ch%0d_k%0d", ch, off), 32'(bus_c.rd_data), 32'(exp));
    endtask

    // Watchdog so the run always reaches its summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int busy_cnt;
        int guard;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.clear = 1'b0; bus_a.wr_en = '0; bus_a.wr_data = '0;
        bus_a.rd_req = 1'b0; bus_a.rd_ch = '0; bus_a.rd_offset = '0;
        bus_b.clear = 1'b0; bus_b.wr_en = '0; bus_b.wr_data = '0;
        bus_b.rd_req = 1'b0; bus_b.rd_ch = '0; bus_b.rd_offset = '0;
        bus_c.clear = 1'b0; bus_c.wr_en = '0; bus_c.wr_data = '0;
        bus_c.rd_req = 1'b0; bus_c.rd_ch = '0; bus_c.rd_offset = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  32'(bus_a.busy), 32'(0));
        chk("rst_valid", 32'(bus_a.rd_valid), 32'(0));
        chk("rst_data",  32'(bus_a.rd_data), 32'(0));
        chk("rst_fill",  32'(bus_a.fill_cnt), 32'(0));
        chk("rst_state", 32'(bus_a.dbg_state), 32'(0));
        rst_n = 1'b1;

        // ch0 gets 1..5, then back-to-back offset reads incl. zero-history
        for (int i = 1; i <= 5; i++) begin
            bus_a.wr_en   = 2'b01;
            bus_a.wr_data = {16'h0000, 16'(i)};
            tick();
        end
        bus_a.wr_en = '0;
        rd_a(0, 0, 16'h0005);
        rd_a(0, 1, 16'h0004);
        rd_a(0, 4, 16'h0001);
        rd_a(0, 5, 16'h0000);
        bus_a.rd_req = 1'b0;
        chk("a_fill_ch0_5", 32'(bus_a.fill_cnt[8:0]), 32'(5));
        chk("a_fill_ch1_0", 32'(bus_a.fill_cnt[17:9]), 32'(0));

        // 300 writes to ch1: wrap and overwrite
        for (int i = 0; i < 300; i++) begin
            bus_a.wr_en   = 2'b10;
            bus_a.wr_data = {16'(i), 16'h0000};
            tick();
        end
        bus_a.wr_en = '0;
        rd_a(1, 0, 16'h012B);
        rd_a(1, 255, 16'h002C);
        bus_a.rd_req = 1'b0;
        chk("a_fill_ch1_sat", 32'(bus_a.fill_cnt[17:9]), 32'(256));

        // Fill ch0, last write 0x55; then write 0xAA with a same-cycle read
        for (int i = 0; i < 250; i++) begin
            bus_a.wr_en   = 2'b01;
            bus_a.wr_data = {16'h0000, 16'(16'h1000 + i)};
            tick();
        end
        bus_a.wr_data = {16'h0000, 16'h0055};
        tick();
        chk("a_fill_ch0_full", 32'(bus_a.fill_cnt[8:0]), 32'(256));
        bus_a.wr_data = {16'h0000, 16'h00AA};
        rd_a(0, 0, 16'h0055);
        bus_a.wr_en = '0;
        rd_a(0, 0, 16'h00AA);
        bus_a.rd_req = 1'b0;

        // Clear with same-cycle write (discarded) and read (pre-clear data)
        bus_a.clear   = 1'b1;
        bus_a.wr_en   = 2'b11;
        bus_a.wr_data = 32'hDEAD_BEEF;
        rd_a(1, 0, 16'h012B);
        bus_a.clear  = 1'b0;
        bus_a.wr_en  = '0;
        bus_a.rd_req = 1'b0;
        busy_cnt = 0;
        guard    = 0;
        while (bus_a.busy && guard < 400) begin
            busy_cnt++;
            guard++;
            bus_a.clear     = 1'($urandom_range(0, 1));
            bus_a.wr_en     = 2'($urandom_range(0, 3));
            bus_a.wr_data   = 32'($urandom);
            bus_a.rd_req    = 1'($urandom_range(0, 1));
            bus_a.rd_ch     = 1'($urandom_range(0, 1));
            bus_a.rd_offset = 8'($urandom_range(0, 255));
            tick();
        end
        bus_a.clear = 1'b0; bus_a.wr_en = '0; bus_a.rd_req = 1'b0;
        chk("a_busy_cycles", 32'(busy_cnt), 32'(256));
        chk("a_clr_fill", 32'(bus_a.fill_cnt), 32'(0));
        rd_a(0, 0, 16'h0000);
        rd_a(1, 7, 16'h0000);
        bus_a.rd_req  = 1'b0;
        bus_a.wr_en   = 2'b01;
        bus_a.wr_data = {16'h0000, 16'h1234};
        tick();
        bus_a.wr_en = '0;
        rd_a(0, 1, 16'h0000);
        rd_a(0, 0, 16'h1234);
        bus_a.rd_req = 1'b0;

        // Async reset with the sweep at address 100
        bus_a.clear = 1'b1;
        tick();
        bus_a.clear = 1'b0;
        repeat (100) tick();
        chk("a_mid_busy", 32'(bus_a.busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",  32'(bus_a.busy), 32'(0));
        chk("ar_valid", 32'(bus_a.rd_valid), 32'(0));
        chk("ar_data",  32'(bus_a.rd_data), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("ar_state", 32'(bus_a.dbg_state), 32'(0));
        bus_a.wr_en   = 2'b01;
        bus_a.wr_data = {16'h0000, 16'h0BEE};
        tick();
        bus_a.wr_en = '0;
        rd_a(0, 0, 16'h0BEE);
        bus_a.rd_req = 1'b0;

        // 4ch/16 build: subset write 1011
        bus_b.wr_en   = 4'b1011;
        bus_b.wr_data = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        tick();
        bus_b.wr_en = '0;
        chk("b_fill0", 32'(bus_b.fill_cnt[4:0]), 32'(1));
        chk("b_fill1", 32'(bus_b.fill_cnt[9:5]), 32'(1));
        chk("b_fill2", 32'(bus_b.fill_cnt[14:10]), 32'(0));
        chk("b_fill3", 32'(bus_b.fill_cnt[19:15]), 32'(1));
        rd_b(3, 0, 16'h0044);
        rd_b(2, 0, 16'h0000);
        bus_b.rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus_b.wr_en   = 4'b0100;
            bus_b.wr_data = {16'h0000, 16'(16'h0200 + i), 32'h0};
            tick();
        end
        bus_b.wr_en = '0;
        chk("b_fill2_sat", 32'(bus_b.fill_cnt[14:10]), 32'(16));
        rd_b(2, 15, 16'h0204);
        rd_b(2, 0, 16'h0213);
        bus_b.rd_req = 1'b0;

        // 3ch/4 build: out-of-range channel reads zero with valid
        bus_c.wr_en   = 3'b100;
        bus_c.wr_data = {16'h0C0C, 32'h0};
        tick();
        bus_c.wr_en = '0;
        rd_c(2, 0, 16'h0C0C);
        rd_c(3, 0, 16'h0000);
        bus_c.rd_req = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
